arm_exec_datapath: RTL and testbench
====================================

Name: arm_exec_datapath

Overview:
- Execute-stage datapath slice of the ARM core: a combinational barrel shifter on operand B, an ALU with registered result and NZCV flags, and the address register with its +4 incrementer.
- Sits between the register bank read buses (busA/busB) and the register-bank write-back/CPSR logic.
- All control inputs come from the instruction decoder.

Parameters:
- WIDTH, 32, datapath width; all buses use this width.
- INC_STEP, 4, constant added by the address incrementer.

Ports:
- clk2  input  1  phase-2 clock; all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- busA  input  32  ALU operand A (Rn)
- busB  input  32  shifter input (Rm value or zero-extended immediate)
- shifter_mode  input  3  shift type
- shifter_count  input  5  shift amount
- alu_invert_a  input  1  use ~A
- alu_invert_b  input  1  use ~B (B = shifter output)
- alu_is_logic  input  1  1 = logic op, 0 = add
- alu_logic_idx  input  3  logic op select
- alu_cin  input  1  adder carry-in
- alu_active  input  1  capture ALU result/flags this cycle
- ale  input  1  address latch enable
- abe  input  1  address bus enable
- alubus  input  32  address register load value
- shifter_output  output  32  barrel shifter result (combinational)
- alu_result  output  32  registered ALU result
- alu_N, alu_Z, alu_C, alu_V  output  1 each  registered flags
- incrementerbus  output  32  address register + INC_STEP (combinational)
- ar  output  32  address bus

Behaviour:
- Reset (rst_n=0, async): alu_result, all four flags and the internal address register clear to 0 immediately. The register holds reset while rst_n is low.
- Shifter (combinational, count n = shifter_count):
  - mode 0 LSL: busB << n, zero fill.
  - mode 1 LSR: busB >> n, zero fill.
  - mode 2 ASR: sign fill.
  - mode 3 ROR: rotate right by n.
  - modes 4-7: pass busB unchanged.
  - n=0 passes busB for every mode.
- ALU operands: A' = alu_invert_a ? ~busA : busA; B' = alu_invert_b ? ~shifter_output : shifter_output.
- Arithmetic (alu_is_logic=0): {cout,sum} = A' + B' + alu_cin, 33-bit. Decoder encodings:
  - ADD: 0,0,cin 0.
  - SUB: inv_b, cin 1.
  - RSB: inv_a, cin 1.
- Logic (alu_is_logic=1), by alu_logic_idx:
  - 0 AND, 1 ORR, 2 EOR, 3 MOV (B').
  - 4-7 pass A'.
  - BIC = AND with inv_b; MVN = MOV with inv_b.
- Flags:
  - N = res[31]; Z = (res==0).
  - Arithmetic: C = cout; V = (A'[31]==B'[31]) && (res[31]!=A'[31]).
  - Logic: C = 0, V = 0.
- Register update: on rising clk2 with alu_active=1, result and flags are captured. With alu_active=0 they hold. Latency is 1 clk2 edge.
- Address register:
  - On rising clk2 with ale=1, it loads alubus; otherwise it holds.
  - incrementerbus = register + INC_STEP, wrapping mod 2^32 (0xFFFFFFFC -> 0x00000000).
  - ar = register when abe=1, else 0.
- Simultaneous events: reset dominates ale and alu_active. Inputs changing between edges affect only combinational outputs.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> alu_result=0, flags 0, ar=0 (abe=1), incrementerbus=4 immediately, without a clock edge.
- Immediate rotate: busB=0x0000000F, mode 3, count 4 -> shifter_output=0xF0000000. Mode 0, count 0 -> 0x0000000F.
- ADD: busA=0xFFFFFFF0, busB=0x0000000F, count 0, add with cin 0, alu_active=1, one edge -> alu_result=0xFFFFFFFF, N=1, Z=0, C=0, V=0.
- SUB with overflow and zero:
  - 0x80000000 - 1 (inv_b, cin 1) -> 0x7FFFFFFF, N=0, C=1, V=1.
  - 5 - 5 -> result 0, Z=1, C=1.
- Logic and hold:
  - AND 0xFFFFFFF0 & 0x0000000F -> 0, Z=1.
  - EOR -> 0xFFFFFFFF.
  - BIC 0xFF & ~0x0F -> 0xF0.
  - With alu_active=0, an edge leaves the previous values unchanged.
- Address register:
  - ale=1, alubus=0x00001000, edge -> ar=0x00001000, incrementerbus=0x00001004.
  - abe=0 -> ar=0.
  - ale=0 with new alubus -> holds.
  - Load 0xFFFFFFFC -> incrementerbus=0.

Source files
------------

// File: rtl/arm_exec_datapath.sv
// Execute-stage datapath slice: barrel shifter on operand B, ALU with registered
// result and NZCV flags, and the address register with its incrementer.
module arm_exec_datapath #(
  parameter int WIDTH    = 32,
  parameter int INC_STEP = 4
) (
  input  logic             clk2,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic [2:0]       shifter_mode,
  input  logic [4:0]       shifter_count,
  input  logic             alu_invert_a,
  input  logic             alu_invert_b,
  input  logic             alu_is_logic,
  input  logic [2:0]       alu_logic_idx,
  input  logic             alu_cin,
  input  logic             alu_active,
  input  logic             ale,
  input  logic             abe,
  input  logic [WIDTH-1:0] alubus,
  output logic [WIDTH-1:0] shifter_output,
  output logic [WIDTH-1:0] alu_result,
  output logic             alu_N,
  output logic             alu_Z,
  output logic             alu_C,
  output logic             alu_V,
  output logic [WIDTH-1:0] incrementerbus,
  output logic [WIDTH-1:0] ar
);

  logic [WIDTH-1:0] shift_s;
  logic [WIDTH-1:0] a_op_s;
  logic [WIDTH-1:0] b_op_s;
  logic [WIDTH-1:0] logic_s;
  logic [WIDTH-1:0] res_s;
  logic [WIDTH:0]   sum_s;
  logic             c_s;
  logic             v_s;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] addr_r;
  logic             n_r;
  logic             z_r;
  logic             c_r;
  logic             v_r;

  // Barrel shifter; a zero count passes busB through for every mode
  always_comb begin
    shift_s = busB;
    if (shifter_count == 5'd0) begin
      shift_s = busB;
    end else begin
      case (shifter_mode)
        3'd0:    shift_s = busB << shifter_count;
        3'd1:    shift_s = busB >> shifter_count;
        3'd2:    shift_s = $signed(busB) >>> shifter_count;
        3'd3:    shift_s = (busB >> shifter_count) | (busB << (WIDTH - int'(shifter_count)));
        default: shift_s = busB;
      endcase
    end
  end

  // ALU: optional operand inversion, then adder or logic unit, plus next flags
  always_comb begin
    a_op_s = alu_invert_a ? ~busA : busA;
    b_op_s = alu_invert_b ? ~shift_s : shift_s;
    sum_s  = {1'b0, a_op_s} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, alu_cin};
    case (alu_logic_idx)
      3'd0:    logic_s = a_op_s & b_op_s;
      3'd1:    logic_s = a_op_s | b_op_s;
      3'd2:    logic_s = a_op_s ^ b_op_s;
      3'd3:    logic_s = b_op_s;
      default: logic_s = a_op_s;
    endcase
    if (alu_is_logic) begin
      res_s = logic_s;
      c_s   = 1'b0;
      v_s   = 1'b0;
    end else begin
      res_s = sum_s[WIDTH-1:0];
      c_s   = sum_s[WIDTH];
      v_s   = (a_op_s[WIDTH-1] == b_op_s[WIDTH-1]) && (res_s[WIDTH-1] != a_op_s[WIDTH-1]);
    end
  end

  // Result/flag capture and address register load
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      res_r  <= {WIDTH{1'b0}};
      n_r    <= 1'b0;
      z_r    <= 1'b0;
      c_r    <= 1'b0;
      v_r    <= 1'b0;
      addr_r <= {WIDTH{1'b0}};
    end else begin
      if (alu_active) begin
        res_r <= res_s;
        n_r   <= res_s[WIDTH-1];
        z_r   <= (res_s == {WIDTH{1'b0}});
        c_r   <= c_s;
        v_r   <= v_s;
      end
      if (ale) begin
        addr_r <= alubus;
      end
    end
  end

  assign shifter_output = shift_s;
  assign alu_result     = res_r;
  assign alu_N          = n_r;
  assign alu_Z          = z_r;
  assign alu_C          = c_r;
  assign alu_V          = v_r;
  assign incrementerbus = addr_r + WIDTH'(INC_STEP);
  assign ar             = abe ? addr_r : {WIDTH{1'b0}};

endmodule

// File: tb/tb_arm_exec_datapath.sv
// Scoreboard bench for arm_exec_datapath: stimulus pushes expected post-edge state,
// a negedge monitor pops and compares against the DUT.
module tb_arm_exec_datapath;

  logic        clk2 = 1'b0;
  logic        rst_n;
  logic [31:0] busA, busB, alubus;
  logic [2:0]  shifter_mode, alu_logic_idx;
  logic [4:0]  shifter_count;
  logic        alu_invert_a, alu_invert_b, alu_is_logic, alu_cin, alu_active, ale, abe;
  logic [31:0] shifter_output, alu_result, incrementerbus, ar;
  logic        alu_N, alu_Z, alu_C, alu_V;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  nzcv;
    logic [31:0] inc;
    logic [31:0] ar;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] m_res  = 32'd0;
  logic [3:0]  m_nzcv = 4'd0;
  logic [31:0] m_addr = 32'd0;

  arm_exec_datapath dut (
    .clk2(clk2), .rst_n(rst_n), .busA(busA), .busB(busB),
    .shifter_mode(shifter_mode), .shifter_count(shifter_count),
    .alu_invert_a(alu_invert_a), .alu_invert_b(alu_invert_b),
    .alu_is_logic(alu_is_logic), .alu_logic_idx(alu_logic_idx),
    .alu_cin(alu_cin), .alu_active(alu_active), .ale(ale), .abe(abe),
    .alubus(alubus), .shifter_output(shifter_output), .alu_result(alu_result),
    .alu_N(alu_N), .alu_Z(alu_Z), .alu_C(alu_C), .alu_V(alu_V),
    .incrementerbus(incrementerbus), .ar(ar)
  );

  always #5 clk2 = ~clk2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Reference shifter: applies the shift one bit position at a time
  function automatic logic [31:0] m_shift(input logic [31:0] b, input logic [2:0] mode, input int n);
    logic [31:0] r;
    r = b;
    if (mode > 3'd3) return b;
    for (int i = 0; i < n; i++) begin
      case (mode)
        3'd0:    r = r * 32'd2;
        3'd1:    r = r / 32'd2;
        3'd2:    r = {r[31], r[31:1]};
        default: r = {r[0], r[31:1]};
      endcase
    end
    return r;
  endfunction

  // Reference ALU using 64-bit integer arithmetic for carry and signed overflow
  task automatic m_alu(output logic [31:0] res, output logic [3:0] nzcv);
    logic [31:0] a, b;
    longint unsigned us;
    longint sa, sb, ss;
    logic c, v;
    a = alu_invert_a ? ~busA : busA;
    b = m_shift(busB, shifter_mode, int'(shifter_count));
    if (alu_invert_b) b = ~b;
    c = 1'b0;
    v = 1'b0;
    if (alu_is_logic) begin
      case (alu_logic_idx)
        3'd0:    res = a & b;
        3'd1:    res = a | b;
        3'd2:    res = a ^ b;
        3'd3:    res = b;
        default: res = a;
      endcase
    end else begin
      us  = longint'(a) + longint'(b) + longint'(alu_cin);
      res = us[31:0];
      c   = us[32];
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ss  = sa + sb + longint'(alu_cin);
      v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    end
    nzcv = {res[31], res == 32'd0, c, v};
  endtask

  // One clk2 cycle: check the shifter, predict post-edge state, then advance
  task automatic step();
    exp_t e;
    logic [31:0] r;
    logic [3:0]  f;
    #1;
    check("shifter", shifter_output, m_shift(busB, shifter_mode, int'(shifter_count)));
    if (alu_active) begin
      m_alu(r, f);
      m_res  = r;
      m_nzcv = f;
    end
    if (ale) m_addr = alubus;
    e.res  = m_res;
    e.nzcv = m_nzcv;
    e.inc  = m_addr + 32'd4;
    e.ar   = abe ? m_addr : 32'd0;
    exp_q.push_back(e);
    @(posedge clk2);
    @(negedge clk2);
    #1;
  endtask

  task automatic set_alu(input logic ia, input logic ib, input logic lg, input logic [2:0] idx, input logic cin);
    alu_invert_a  = ia;
    alu_invert_b  = ib;
    alu_is_logic  = lg;
    alu_logic_idx = idx;
    alu_cin       = cin;
  endtask

  // Monitor: compares registered state after every edge that has an expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk2);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("mon_result", alu_result, e.res);
        check("mon_nzcv", {28'd0, alu_N, alu_Z, alu_C, alu_V}, {28'd0, e.nzcv});
        check("mon_inc", incrementerbus, e.inc);
        check("mon_ar", ar, e.ar);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    busA = 32'd0; busB = 32'd0; alubus = 32'd0;
    shifter_mode = 3'd0; shifter_count = 5'd0;
    set_alu(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    alu_active = 1'b0; ale = 1'b0; abe = 1'b1;
    #1;
    check("rst_result", alu_result, 32'd0);
    check("rst_nzcv", {28'd0, alu_N, alu_Z, alu_C, alu_V}, 32'd0);
    check("rst_ar", ar, 32'd0);
    check("rst_inc", incrementerbus, 32'd4);
    @(negedge clk2); @(negedge clk2);
    #1 rst_n = 1'b1;

    // Shifter directed cases
    busB = 32'h0000000F; shifter_mode = 3'd3; shifter_count = 5'd4;
    #1 check("ror_imm", shifter_output, 32'hF0000000);
    shifter_mode = 3'd0; shifter_count = 5'd0;
    #1 check("lsl_zero", shifter_output, 32'h0000000F);

    // ADD
    busA = 32'hFFFFFFF0; alu_active = 1'b1;
    set_alu(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    check("add_res", alu_result, 32'hFFFFFFFF);
    check("add_nzcv", {28'd0, alu_N, alu_Z, alu_C, alu_V}, 32'h8);

    // SUB with overflow, then SUB to zero
    busA = 32'h80000000; busB = 32'd1;
    set_alu(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    step();
    check("subv_res", alu_result, 32'h7FFFFFFF);
    check("subv_nzcv", {28'd0, alu_N, alu_Z, alu_C, alu_V}, 32'h3);
    busA = 32'd5; busB = 32'd5;
    step();
    check("subz_res", alu_result, 32'd0);
    check("subz_nzcv", {28'd0, alu_N, alu_Z, alu_C, alu_V}, 32'h6);

    // Logic ops: AND, EOR, BIC
    busA = 32'hFFFFFFF0; busB = 32'h0000000F;
    set_alu(1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    step();
    check("and_res", alu_result, 32'd0);
    check("and_z", {31'd0, alu_Z}, 32'd1);
    alu_logic_idx = 3'd2;
    step();
    check("eor_res", alu_result, 32'hFFFFFFFF);
    busA = 32'h000000FF; busB = 32'h0000000F;
    set_alu(1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
    step();
    check("bic_res", alu_result, 32'h000000F0);

    // Hold with alu_active low
    alu_active = 1'b0; busA = 32'h12345678; alu_logic_idx = 3'd1;
    step();
    check("hold_res", alu_result, 32'h000000F0);

    // Address register
    ale = 1'b1; alubus = 32'h00001000;
    step();
    check("ar_load", ar, 32'h00001000);
    check("inc_load", incrementerbus, 32'h00001004);
    ale = 1'b0; abe = 1'b0;
    #1 check("ar_abe0", ar, 32'd0);
    abe = 1'b1; alubus = 32'h00002000;
    step();
    check("ar_hold", ar, 32'h00001000);
    ale = 1'b1; alubus = 32'hFFFFFFFC;
    step();
    check("inc_wrap", incrementerbus, 32'd0);

    // Mid-cycle asynchronous reset, held across an edge with ale/alu_active set
    ale = 1'b1; alu_active = 1'b1; alubus = 32'h0000ABCD;
    set_alu(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    busA = 32'h11111111; busB = 32'h22222222;
    #2 rst_n = 1'b0;
    #1;
    check("arst_result", alu_result, 32'd0);
    check("arst_ar", ar, 32'd0);
    check("arst_inc", incrementerbus, 32'd4);
    @(posedge clk2);
    #1;
    check("arst_hold_res", alu_result, 32'd0);
    check("arst_hold_nzcv", {28'd0, alu_N, alu_Z, alu_C, alu_V}, 32'd0);
    check("arst_hold_ar", ar, 32'd0);
    @(negedge clk2);
    #1 rst_n = 1'b1;
    m_res = 32'd0; m_nzcv = 4'd0; m_addr = 32'd0;

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      busA          = $urandom;
      busB          = $urandom;
      shifter_mode  = 3'($urandom_range(0, 7));
      shifter_count = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      set_alu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      alu_active    = ($urandom_range(0, 3) != 0);
      ale           = 1'($urandom_range(0, 1));
      abe           = 1'($urandom_range(0, 1));
      alubus        = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      step();
    end

    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
